multicycle_control_unit: RTL and testbench

- Parametrised successor to the single-cycle combinational decoder: FSM that sequences the multicycle MIPS datapath (shared ALU, IR/MDR/ALUOut registers) over FETCH/DECODE/EXEC/MEM/WB.
- Handles variable-latency instruction and data memory through ihit/dhit wait handshakes, with an optional memory-wait timeout.
- Applies overflow traps to the correct opcode subset only, and counts retired instructions.
- Sits between the datapath and the memory arbiter.

---
 rtl/cpu_types_pkg.sv | 109 ++++++++++
 rtl/multicycle_control_unit_decode.sv | 62 ++++++
 rtl/multicycle_control_unit.sv | 155 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared MIPS control types: opcodes, functs, ALU operations, multicycle FSM
// states, datapath select encodings and the per-state control word.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
    OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT = 6'h3E
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20,
    FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
    FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R,
    WB_I, WB_MEM, BRANCH, JUMP, JAL, JR, HALT
  } state_t;

  localparam logic [1:0] PCSRC_ALU      = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT   = 2'd1;
  localparam logic [1:0] PCSRC_JUMP     = 2'd2;
  localparam logic [1:0] PCSRC_RS       = 2'd3;
  localparam logic [1:0] REGDST_RT      = 2'd0;
  localparam logic [1:0] REGDST_RD      = 2'd1;
  localparam logic [1:0] REGDST_RA      = 2'd2;
  localparam logic [1:0] MEMTOREG_ALU   = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR   = 2'd1;
  localparam logic [1:0] MEMTOREG_PC    = 2'd2;
  localparam logic [1:0] SRCB_RT        = 2'd0;
  localparam logic [1:0] SRCB_FOUR      = 2'd1;
  localparam logic [1:0] SRCB_IMM       = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2   = 2'd3;
  localparam logic [1:0] EXT_ZERO       = 2'd0;
  localparam logic [1:0] EXT_SIGN       = 2'd1;
  localparam logic [1:0] EXT_LUI        = 2'd2;

  typedef struct packed {
    logic       iren;
    logic       dren;
    logic       dwen;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] extop;
    logic       shamt_sel;
    logic [1:0] pcsrc;
    aluop_t     aluop;
  } ctrl_t;

  // Control word presented while the FSM sits in state s. FETCH's irwrite
  // marks the fetch window; the top gates the real IR/PC writes with ihit.
  function automatic ctrl_t ctrl_for(input state_t s, input aluop_t ex_aluop,
                                     input logic [1:0] ex_extop, input logic ex_shamt);
    ctrl_t c;
    c = '0;
    c.aluop = ALU_SLL;
    case (s)
      FETCH: begin
        c.iren = 1'b1; c.irwrite = 1'b1;
        c.alusrcb = SRCB_FOUR; c.aluop = ALU_ADD; c.pcsrc = PCSRC_ALU;
      end
      DECODE: begin
        c.alusrcb = SRCB_IMM_SH2; c.extop = EXT_SIGN; c.aluop = ALU_ADD;
      end
      EXEC_R: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_RT;
        c.aluop = ex_aluop; c.shamt_sel = ex_shamt;
      end
      EXEC_I: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_IMM;
        c.aluop = ex_aluop; c.extop = ex_extop;
      end
      MEM_ADDR: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.extop = EXT_SIGN; c.aluop = ALU_ADD;
      end
      MEM_RD: c.dren = 1'b1;
      MEM_WR: c.dwen = 1'b1;
      WB_R:   begin c.regwrite = 1'b1; c.regdst = REGDST_RD; c.memtoreg = MEMTOREG_ALU; end
      WB_I:   begin c.regwrite = 1'b1; c.regdst = REGDST_RT; c.memtoreg = MEMTOREG_ALU; end
      WB_MEM: begin c.regwrite = 1'b1; c.regdst = REGDST_RT; c.memtoreg = MEMTOREG_MDR; end
      BRANCH: begin
        c.alusrca = 1'b1; c.alusrcb = SRCB_RT; c.aluop = ALU_SUB; c.pcsrc = PCSRC_ALUOUT;
      end
      JUMP: begin c.pcwrite = 1'b1; c.pcsrc = PCSRC_JUMP; end
      JAL: begin
        c.pcwrite = 1'b1; c.pcsrc = PCSRC_JUMP;
        c.regwrite = 1'b1; c.regdst = REGDST_RA; c.memtoreg = MEMTOREG_PC;
      end
      JR: begin c.pcwrite = 1'b1; c.pcsrc = PCSRC_RS; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// Combinational instruction decoder: opcode/funct to the execute-phase
// state, ALU operation, immediate extension and trap eligibility.
module mcu_decode
  import cpu_types_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output state_t     next_o,
  output aluop_t     aluop_o,
  output logic [1:0] extop_o,
  output logic       shamt_o,
  output logic       trap_o,
  output logic       illegal_o
);

  always_comb begin
    next_o    = FETCH;
    aluop_o   = ALU_ADD;
    extop_o   = EXT_SIGN;
    shamt_o   = 1'b0;
    trap_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_t'(op_i))
      OP_RTYPE: begin
        next_o = EXEC_R;
        case (funct_t'(funct_i))
          FN_SLL:  begin aluop_o = ALU_SLL; shamt_o = 1'b1; end
          FN_SRL:  begin aluop_o = ALU_SRL; shamt_o = 1'b1; end
          FN_JR:   next_o = JR;
          FN_ADD:  begin aluop_o = ALU_ADD; trap_o = 1'b1; end
          FN_ADDU: aluop_o = ALU_ADD;
          FN_SUB:  begin aluop_o = ALU_SUB; trap_o = 1'b1; end
          FN_SUBU: aluop_o = ALU_SUB;
          FN_AND:  aluop_o = ALU_AND;
          FN_OR:   aluop_o = ALU_OR;
          FN_XOR:  aluop_o = ALU_XOR;
          FN_NOR:  aluop_o = ALU_NOR;
          FN_SLT:  aluop_o = ALU_SLT;
          FN_SLTU: aluop_o = ALU_SLTU;
          default: begin next_o = FETCH; illegal_o = 1'b1; end
        endcase
      end
      OP_J:     next_o = JUMP;
      OP_JAL:   next_o = JAL;
      OP_BEQ:   begin next_o = BRANCH; aluop_o = ALU_SUB; end
      OP_BNE:   begin next_o = BRANCH; aluop_o = ALU_SUB; end
      OP_ADDI:  begin next_o = EXEC_I; trap_o = 1'b1; end
      OP_ADDIU: next_o = EXEC_I;
      OP_SLTI:  begin next_o = EXEC_I; aluop_o = ALU_SLT; end
      OP_SLTIU: begin next_o = EXEC_I; aluop_o = ALU_SLTU; end
      OP_ANDI:  begin next_o = EXEC_I; aluop_o = ALU_AND; extop_o = EXT_ZERO; end
      OP_ORI:   begin next_o = EXEC_I; aluop_o = ALU_OR;  extop_o = EXT_ZERO; end
      OP_XORI:  begin next_o = EXEC_I; aluop_o = ALU_XOR; extop_o = EXT_ZERO; end
      OP_LUI:   begin next_o = EXEC_I; aluop_o = ALU_OR;  extop_o = EXT_LUI; end
      OP_LW:    next_o = MEM_ADDR;
      OP_SW:    next_o = MEM_ADDR;
      OP_HALT:  next_o = HALT;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with registered control outputs, memory wait
// handshakes, optional wait timeout, overflow traps and a retire counter.
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter bit          OVF_TRAP    = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      instr,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             zero,
  input  logic             overf,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ExtOp,
  output logic             shamt_sel,
  output logic [1:0]       PCSrc,
  output aluop_t           ALUOP,
  output logic             halt,
  output logic             mem_err,
  output logic             illegal,
  output state_t           state_o,
  output logic [CNT_W-1:0] instr_count
);

  localparam bit             TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [5:0]       op_q, fn_q;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic             halt_q, mem_err_q, illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q;
  logic             waiting, hit, timeout, retire, trap, fetch_done, taken;
  logic             unused_instr_bits;

  state_t     dec_next;
  aluop_t     dec_aluop;
  logic [1:0] dec_extop;
  logic       dec_shamt, dec_trap, dec_illegal;

  assign unused_instr_bits = ^instr[25:6];

  mcu_decode u_decode (
    .op_i      (op_q),
    .funct_i   (fn_q),
    .next_o    (dec_next),
    .aluop_o   (dec_aluop),
    .extop_o   (dec_extop),
    .shamt_o   (dec_shamt),
    .trap_o    (dec_trap),
    .illegal_o (dec_illegal)
  );

  // The first FETCH cycle after reset has iREN low, so ihit only counts once the request is out.
  assign fetch_done = (state_q == FETCH) && ctrl_q.iren && ihit;
  assign waiting    = ((state_q == FETCH) && ctrl_q.iren) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign hit        = (state_q == FETCH) ? ihit : dhit;
  // Fires on the MEM_TIMEOUT-th consecutive waiting cycle without a hit.
  assign timeout    = TMO_EN && waiting && !hit && (wait_q == TMO_LAST);
  assign trap       = OVF_TRAP && overf && dec_trap;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:    if (fetch_done) state_d = DECODE; else if (timeout) state_d = HALT;
      DECODE:   begin state_d = dec_next; illegal_d = dec_illegal; end
      EXEC_R:   state_d = trap ? HALT : WB_R;
      EXEC_I:   state_d = trap ? HALT : WB_I;
      MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (dhit) state_d = WB_MEM; else if (timeout) state_d = HALT;
      MEM_WR: begin
        if (dhit) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = HALT;
        end
      end
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
    wait_d = (waiting && (state_d == state_q)) ? wait_q + TMO_W'(1) : '0;
    ctrl_d = ctrl_for(state_d, dec_aluop, dec_extop, dec_shamt);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      ctrl_q    <= '0;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      halt_q    <= 1'b0;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      halt_q    <= (state_d == HALT);
      illegal_q <= illegal_d;
      if (fetch_done) begin
        op_q <= instr[31:26];
        fn_q <= instr[5:0];
      end
      if (timeout) mem_err_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign taken = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);

  assign iREN        = ctrl_q.iren;
  assign dREN        = ctrl_q.dren;
  assign dWEN        = ctrl_q.dwen;
  assign IRWrite     = ctrl_q.irwrite && ihit;
  assign PCWrite     = ctrl_q.pcwrite || (ctrl_q.irwrite && ihit) || ((state_q == BRANCH) && taken);
  assign RegWrite    = ctrl_q.regwrite;
  assign RegDst      = ctrl_q.regdst;
  assign MemtoReg    = ctrl_q.memtoreg;
  assign ALUSrcA     = ctrl_q.alusrca;
  assign ALUSrcB     = ctrl_q.alusrcb;
  assign ExtOp       = ctrl_q.extop;
  assign shamt_sel   = ctrl_q.shamt_sel;
  assign PCSrc       = ctrl_q.pcsrc;
  assign ALUOP       = ctrl_q.aluop;
  assign halt        = halt_q;
  assign mem_err     = mem_err_q;
  assign illegal     = illegal_q;
  assign state_o     = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one instance without timeout,
// one with MEM_TIMEOUT=4 for the wait-fault cases.
module tb_multicycle_control_unit;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ihit, dhit, zero, overf;
  logic [31:0] instr;
  logic        iren, dren, dwen, irwrite, pcwrite, regwrite, alusrca, shamt, hlt, merr, ill;
  logic [1:0]  regdst, memtoreg, alusrcb, extop, pcsrc;
  aluop_t      aluop;
  state_t      st;
  logic [31:0] icount;

  logic        rst_t, ihit_t;
  logic [31:0] instr_t;
  logic        t_iren, t_dren, t_dwen, t_irwrite, t_pcwrite, t_regwrite, t_alusrca, t_shamt;
  logic        t_halt, t_merr, t_ill;
  logic [1:0]  t_regdst, t_memtoreg, t_alusrcb, t_extop, t_pcsrc;
  aluop_t      t_aluop;
  state_t      t_st;
  logic [31:0] t_icount;

  multicycle_control_unit u_dut (
    .CLK(clk), .RST(rst), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero), .overf(overf),
    .iREN(iren), .dREN(dren), .dWEN(dwen), .IRWrite(irwrite), .PCWrite(pcwrite),
    .RegWrite(regwrite), .RegDst(regdst), .MemtoReg(memtoreg), .ALUSrcA(alusrca),
    .ALUSrcB(alusrcb), .ExtOp(extop), .shamt_sel(shamt), .PCSrc(pcsrc), .ALUOP(aluop),
    .halt(hlt), .mem_err(merr), .illegal(ill), .state_o(st), .instr_count(icount)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(4)) u_tmo (
    .CLK(clk), .RST(rst_t), .instr(instr_t), .ihit(ihit_t), .dhit(1'b0), .zero(1'b0), .overf(1'b0),
    .iREN(t_iren), .dREN(t_dren), .dWEN(t_dwen), .IRWrite(t_irwrite), .PCWrite(t_pcwrite),
    .RegWrite(t_regwrite), .RegDst(t_regdst), .MemtoReg(t_memtoreg), .ALUSrcA(t_alusrca),
    .ALUSrcB(t_alusrcb), .ExtOp(t_extop), .shamt_sel(t_shamt), .PCSrc(t_pcsrc), .ALUOP(t_aluop),
    .halt(t_halt), .mem_err(t_merr), .illegal(t_ill), .state_o(t_st), .instr_count(t_icount)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Waits (bounded) for an active fetch, then supplies the word with ihit.
  task automatic fetch(input string name, input logic [31:0] w);
    int n;
    n = 0;
    while (!(st == FETCH && iren) && n < 20) begin
      tick();
      n++;
    end
    check({name, "_fetch_ready"}, 32'(n < 20), 32'd1);
    instr = w;
    ihit  = 1'b1;
    settle();
    check({name, "_irwrite"}, 32'(irwrite), 32'd1);
    check({name, "_pcwrite_fetch"}, 32'(pcwrite), 32'd1);
    tick();
    ihit = 1'b0;
    check({name, "_decode"}, 32'(st), 32'(DECODE));
    $display("txn %s instr=0x%08h fetched", name, w);
  endtask

  initial begin
    int dren_cyc, bad_halt, bad_rw, n;
    rst = 1'b1; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; overf = 1'b0; instr = '0;
    rst_t = 1'b1; ihit_t = 1'b0; instr_t = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(st), 32'(FETCH));
    check("rst_iren", 32'(iren), 32'd0);
    check("rst_aluop", 32'(aluop), 32'(ALU_SLL));
    check("rst_halt", 32'(hlt), 32'd0);
    check("rst_count", icount, 32'd0);
    rst = 1'b0; rst_t = 1'b0;

    // Timeout instance: hit on the 4th wait cycle wins, then a silent fetch faults.
    n = 0;
    while (!t_iren && n < 20) begin tick(); n++; end
    check("tmo_iren_up", 32'(n < 20), 32'd1);
    repeat (3) tick();
    ihit_t = 1'b1; instr_t = 32'h00221821;
    settle();
    tick();
    ihit_t = 1'b0;
    check("tmo_hit_wins_state", 32'(t_st), 32'(DECODE));
    check("tmo_hit_wins_err", 32'(t_merr), 32'd0);
    repeat (3) tick();
    check("tmo_back_fetch", 32'(t_st), 32'(FETCH));
    repeat (3) tick();
    check("tmo_still_waiting", 32'(t_st), 32'(FETCH));
    tick();
    check("tmo_halt_state", 32'(t_st), 32'(HALT));
    check("tmo_mem_err", 32'(t_merr), 32'd1);
    check("tmo_halt", 32'(t_halt), 32'd1);
    $display("txn timeout sequence done");

    fetch("addu", 32'h00221821);
    tick();
    check("addu_exec", 32'(st), 32'(EXEC_R));
    check("addu_aluop", 32'(aluop), 32'(ALU_ADD));
    check("addu_srca", 32'(alusrca), 32'd1);
    check("addu_rw_exec", 32'(regwrite), 32'd0);
    tick();
    check("addu_wb", 32'(st), 32'(WB_R));
    check("addu_rw", 32'(regwrite), 32'd1);
    check("addu_regdst", 32'(regdst), 32'd1);
    tick();
    check("addu_rw_off", 32'(regwrite), 32'd0);
    check("addu_count", icount, 32'd1);

    fetch("lw", 32'h8C220004);
    tick();
    check("lw_memaddr", 32'(st), 32'(MEM_ADDR));
    check("lw_srcb", 32'(alusrcb), 32'd2);
    tick();
    dren_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      dhit = (i == 2);
      settle();
      if (dren) dren_cyc++;
      tick();
    end
    dhit = 1'b0;
    check("lw_dren_cycles", 32'(dren_cyc), 32'd3);
    check("lw_dren_off", 32'(dren), 32'd0);
    check("lw_wbmem", 32'(st), 32'(WB_MEM));
    check("lw_rw", 32'(regwrite), 32'd1);
    check("lw_memtoreg", 32'(memtoreg), 32'd1);
    check("lw_regdst", 32'(regdst), 32'd0);
    tick();
    check("lw_count", icount, 32'd2);

    fetch("addu_ovf", 32'h00221821);
    tick();
    overf = 1'b1;
    settle();
    tick();
    overf = 1'b0;
    check("addu_ovf_wb", 32'(st), 32'(WB_R));
    tick();
    check("addu_ovf_count", icount, 32'd3);

    fetch("beq", 32'h10220003);
    tick();
    zero = 1'b1;
    settle();
    check("beq_state", 32'(st), 32'(BRANCH));
    check("beq_pcwrite", 32'(pcwrite), 32'd1);
    check("beq_pcsrc", 32'(pcsrc), 32'd1);
    check("beq_aluop", 32'(aluop), 32'(ALU_SUB));
    tick();
    check("beq_count", icount, 32'd4);

    fetch("bne", 32'h14220003);
    tick();
    settle();
    check("bne_z1_pcwrite", 32'(pcwrite), 32'd0);
    zero = 1'b0;
    settle();
    check("bne_z0_pcwrite", 32'(pcwrite), 32'd1);
    tick();
    check("bne_count", icount, 32'd5);

    fetch("illegal", 32'hFC000000);
    check("ill_pre", 32'(ill), 32'd0);
    tick();
    check("ill_pulse", 32'(ill), 32'd1);
    check("ill_state", 32'(st), 32'(FETCH));
    tick();
    check("ill_pulse_end", 32'(ill), 32'd0);
    check("ill_count", icount, 32'd5);

    fetch("jal", 32'h0C000010);
    tick();
    check("jal_state", 32'(st), 32'(JAL));
    check("jal_pcwrite", 32'(pcwrite), 32'd1);
    check("jal_pcsrc", 32'(pcsrc), 32'd2);
    check("jal_rw", 32'(regwrite), 32'd1);
    check("jal_regdst", 32'(regdst), 32'd2);
    check("jal_memtoreg", 32'(memtoreg), 32'd2);
    tick();
    check("jal_count", icount, 32'd6);

    fetch("sltiu", 32'h2C220005);
    tick();
    check("sltiu_state", 32'(st), 32'(EXEC_I));
    check("sltiu_aluop", 32'(aluop), 32'(ALU_SLTU));
    check("sltiu_extop", 32'(extop), 32'd1);
    tick();
    check("sltiu_wb", 32'(st), 32'(WB_I));
    check("sltiu_regdst", 32'(regdst), 32'd0);
    tick();

    fetch("ori", 32'h34220005);
    tick();
    check("ori_aluop", 32'(aluop), 32'(ALU_OR));
    check("ori_extop", 32'(extop), 32'd0);
    repeat (2) tick();
    check("ori_count", icount, 32'd8);

    fetch("sw", 32'h AC220004);
    repeat (2) tick();
    settle();
    check("sw_state", 32'(st), 32'(MEM_WR));
    check("sw_dwen", 32'(dwen), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("sw_rst_dwen", 32'(dwen), 32'd0);
    check("sw_rst_state", 32'(st), 32'(FETCH));
    check("sw_rst_count", icount, 32'd0);
    #1 rst = 1'b0;
    tick();
    check("post_rst_state", 32'(st), 32'(FETCH));
    check("post_rst_count", icount, 32'd0);

    fetch("add_trap", 32'h00221820);
    tick();
    overf = 1'b1;
    settle();
    tick();
    overf = 1'b0;
    check("trap_state", 32'(st), 32'(HALT));
    check("trap_halt", 32'(hlt), 32'd1);
    check("trap_rw", 32'(regwrite), 32'd0);
    bad_halt = 0;
    bad_rw   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hlt !== 1'b1) bad_halt++;
      if (regwrite !== 1'b0) bad_rw++;
    end
    check("trap_halt_sticky", 32'(bad_halt), 32'd0);
    check("trap_no_rw", 32'(bad_rw), 32'd0);
    check("trap_count", icount, 32'd0);
    $display("txn add overflow trap done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
